// File: rtl/lsu_ctrl_pkg.sv
// Shared funct3 codes, FSM state encoding and small decode helpers for the LSU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_ctrl_pkg;

    // Load funct3 codes
    localparam logic [2:0] L_BYTE   = 3'b000;
    localparam logic [2:0] L_HALF   = 3'b001;
    localparam logic [2:0] L_WORD   = 3'b010;
    localparam logic [2:0] L_BYTE_U = 3'b100;
    localparam logic [2:0] L_HALF_U = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] S_BYTE   = 3'b000;
    localparam logic [2:0] S_HALF   = 3'b001;
    localparam logic [2:0] S_WORD   = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        ST_MERGE = 2'd2,
        RESP     = 2'd3
    } lsu_state_t;

    // Loads accept B/H/W/BU/HU; anything else is illegal
    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == L_BYTE) || (f3 == L_HALF) || (f3 == L_WORD) ||
               (f3 == L_BYTE_U) || (f3 == L_HALF_U);
    endfunction

    // Stores accept B/H/W only
    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == S_BYTE) || (f3 == S_HALF) || (f3 == S_WORD);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundles the EX request, RAM port and writeback response signals of the LSU.
// Latency: n/a (wiring only).
// Backpressure: req_ready is driven by the slave (the LSU).
interface lsu_ctrl_if #(
    parameter int RAM_AW = 10
);
    // EX request
    logic              req_valid;
    logic              req_ready;
    logic              req_re;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    // Data RAM port
    logic              mem_re;
    logic [RAM_AW-1:0] mem_raddr;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [RAM_AW-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // Writeback response
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_data;

    // LSU side
    modport slave (
        input  req_valid, req_re, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready,
        output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
        output resp_valid, resp_err, resp_data
    );

    // Pipeline + RAM side
    modport master (
        output req_valid, req_re, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready,
        input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
        input  resp_valid, resp_err, resp_data
    );

endinterface

// File: rtl/lsu_ctrl_align.sv
// Combinational lane logic: request legality check, load extract/extend, store lane merge.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing FSM decides when results are used.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    // Live request, checked in the accept cycle
    input  logic        chk_re,
    input  logic        chk_we,
    input  logic [2:0]  chk_funct3,
    input  logic [31:0] chk_addr,
    output logic        chk_err,

    // Latched op, used one cycle after accept
    input  logic [2:0]  op_funct3,
    input  logic [1:0]  op_off,
    input  logic [15:0] op_wdata,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Flag any request that must complete with an error and no RAM access
    always_comb begin
        logic f3_ok;
        logic misaligned;
        logic out_of_range;
        f3_ok        = chk_re ? load_f3_legal(chk_funct3) : store_f3_legal(chk_funct3);
        // H/HU share funct3[1:0]=01, W is 10
        misaligned   = ((chk_funct3[1:0] == 2'b01) && chk_addr[0]) ||
                       ((chk_funct3[1:0] == 2'b10) && (chk_addr[1:0] != 2'b00));
        out_of_range = (chk_addr >= 32'(MEM_BYTES));
        chk_err      = (chk_re == chk_we) || !f3_ok || misaligned || out_of_range;
    end

    // Pick the addressed byte and halfword lanes out of the RAM word
    always_comb begin
        byte_sel = rdata[7:0];
        case (op_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = op_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign- or zero-extend the selected lane to a full register value
    always_comb begin
        ld_data = rdata;
        case (op_funct3)
            L_BYTE:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            L_BYTE_U: ld_data = {24'd0, byte_sel};
            L_HALF:   ld_data = {{16{half_sel[15]}}, half_sel};
            L_HALF_U: ld_data = {16'd0, half_sel};
            default:  ld_data = rdata;
        endcase
    end

    // Overlay the store lane onto the word just read back for SB/SH
    always_comb begin
        st_data = rdata;
        if (op_funct3 == S_HALF) begin
            if (op_off[1]) begin
                st_data[31:16] = op_wdata;
            end else begin
                st_data[15:0] = op_wdata;
            end
        end else begin
            case (op_off)
                2'd0:    st_data[7:0]   = op_wdata[7:0];
                2'd1:    st_data[15:8]  = op_wdata[7:0];
                2'd2:    st_data[23:16] = op_wdata[7:0];
                default: st_data[31:24] = op_wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX and a 1-cycle synchronous word RAM, with SB/SH read-modify-write.
// Latency: loads and SB/SH respond 2 cycles after accept, SW and errors 1 cycle after accept.
// Backpressure: req_ready is high only in IDLE; one op is in flight at a time.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int RAM_AW    = 10
) (
    input  logic    clk,
    input  logic    reset,
    lsu_ctrl_if.slave bus
);

    lsu_state_t        state;

    // Fields captured at accept so later request changes cannot disturb the op
    logic [RAM_AW-1:0] op_waddr;
    logic [1:0]        op_off;
    logic [2:0]        op_funct3;
    logic [15:0]       op_wdata;

    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_data_q;

    logic              chk_err;
    logic [31:0]       ld_data;
    logic [31:0]       st_data;

    logic              accept;
    logic              acc_ok;
    logic              acc_load;
    logic              acc_sw;
    logic              acc_rmw;

    lsu_align #(
        .MEM_BYTES (MEM_BYTES)
    ) u_align (
        .chk_re     (bus.req_re),
        .chk_we     (bus.req_we),
        .chk_funct3 (bus.req_funct3),
        .chk_addr   (bus.req_addr),
        .chk_err    (chk_err),
        .op_funct3  (op_funct3),
        .op_off     (op_off),
        .op_wdata   (op_wdata),
        .rdata      (bus.mem_rdata),
        .ld_data    (ld_data),
        .st_data    (st_data)
    );

    // Reset gates ready so nothing is accepted (and no RAM strobe fires) while held
    assign bus.req_ready = (state == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign acc_ok        = accept && !chk_err;
    assign acc_load      = acc_ok && bus.req_re;
    assign acc_sw        = acc_ok && bus.req_we && (bus.req_funct3 == S_WORD);
    assign acc_rmw       = acc_ok && bus.req_we && (bus.req_funct3 != S_WORD);

    // RAM strobes: reads and SW go out in the accept cycle, the SB/SH write one cycle later
    assign bus.mem_re    = acc_load || acc_rmw;
    assign bus.mem_raddr = bus.req_addr[RAM_AW+1:2];
    assign bus.mem_we    = acc_sw || (state == ST_MERGE);
    assign bus.mem_waddr = (state == ST_MERGE) ? op_waddr : bus.req_addr[RAM_AW+1:2];
    assign bus.mem_wdata = (state == ST_MERGE) ? st_data  : bus.req_wdata;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_data  = resp_data_q;

    // Sequencer: accept, wait for RAM data or merge, then pulse the response for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_waddr     <= '0;
            op_off       <= 2'd0;
            op_funct3    <= 3'd0;
            op_wdata     <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_waddr  <= bus.req_addr[RAM_AW+1:2];
                        op_off    <= bus.req_addr[1:0];
                        op_funct3 <= bus.req_funct3;
                        op_wdata  <= bus.req_wdata[15:0];
                        if (chk_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= 32'd0;
                            state        <= RESP;
                        end else if (bus.req_re) begin
                            state <= LD_WAIT;
                        end else if (bus.req_funct3 == S_WORD) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_data_q  <= 32'd0;
                            state        <= RESP;
                        end else begin
                            state <= ST_MERGE;
                        end
                    end
                end
                LD_WAIT: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= ld_data;
                    state        <= RESP;
                end
                ST_MERGE: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= 32'd0;
                    state        <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural RAM and a response scoreboard.
// Latency: checks 2-cycle loads/RMW stores and 1-cycle SW/errors.
// Backpressure: stimulus waits on req_ready before issuing each op.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] data;
        int          t_acc;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    logic preload;
    int   cyc;
    int   checks;
    int   passes;
    int   n_re;
    int   n_we;
    exp_t sbq[$];

    logic [31:0] ram [0:1023];

    lsu_ctrl_if #(.RAM_AW(10)) bus ();

    lsu_ctrl #(
        .MEM_BYTES (4096),
        .RAM_AW    (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM with 1-cycle read latency
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'd0;
            ram[4]    <= 32'h8899AABB;
            ram[5]    <= 32'h11223344;
            ram[1023] <= 32'hCAFEF00D;
        end else begin
            if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
            if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_raddr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Count RAM strobes, sampled well after inputs settle
    always @(negedge clk) begin
        #2;
        if (bus.mem_re === 1'b1) n_re++;
        if (bus.mem_we === 1'b1) n_we++;
    end

    // Scoreboard monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_err"},  32'(bus.resp_err), 32'(e.err));
                chk({e.name, "_data"}, bus.resp_data, e.data);
                chk({e.name, "_lat"},  32'(cyc - e.t_acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic re, input logic we,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_data, input int lat,
                         input bit push, output int t_acc);
        int   guard;
        logic exp_re;
        logic exp_we;
        exp_t e;
        guard = 0;
        t_acc = -1;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (bus.req_ready !== 1'b1) begin
            chk({name, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_re     = re;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        #1;
        t_acc  = cyc;
        exp_re = !exp_err && (re || (f3 != S_WORD));
        exp_we = !exp_err && we && (f3 == S_WORD);
        chk({name, "_mem_re_T"}, 32'(bus.mem_re), 32'(exp_re));
        chk({name, "_mem_we_T"}, 32'(bus.mem_we), 32'(exp_we));
        if (exp_re) chk({name, "_raddr"}, 32'(bus.mem_raddr), 32'(addr[11:2]));
        if (exp_we) begin
            chk({name, "_waddr"}, 32'(bus.mem_waddr), 32'(addr[11:2]));
            chk({name, "_wdata"}, bus.mem_wdata, wdata);
        end
        if (push) begin
            e.name = name; e.err = exp_err; e.data = exp_data; e.t_acc = t_acc; e.lat = lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble the request after accept; the op must use its latched copy
        bus.req_valid  = 1'b0;
        bus.req_re     = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFC;
        bus.req_wdata  = 32'hDEAD_BEEF;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            chk({name, "_drain_timeout"}, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        int t;
        int t_sw;
        int t_lw;
        int acc_before;
        checks = 0; passes = 0; cyc = 0; n_re = 0; n_we = 0;
        reset = 1'b1; preload = 1'b1;
        bus.req_valid = 1'b0; bus.req_re = 1'b0; bus.req_we = 1'b0;
        bus.req_funct3 = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst_resp_data",  bus.resp_data,       32'd0);
        chk("rst_mem_re",     32'(bus.mem_re),     32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready),  32'd1);

        // Loads from word 0x10 = 0x8899AABB
        issue("lb_13",  1, 0, L_BYTE,   32'h13, 0, 0, 32'hFFFFFF88, 2, 1, t);
        issue("lbu_13", 1, 0, L_BYTE_U, 32'h13, 0, 0, 32'h00000088, 2, 1, t);
        issue("lh_12",  1, 0, L_HALF,   32'h12, 0, 0, 32'hFFFF8899, 2, 1, t);
        issue("lhu_10", 1, 0, L_HALF_U, 32'h10, 0, 0, 32'h0000AABB, 2, 1, t);
        issue("lw_ffc", 1, 0, L_WORD,  32'hFFC, 0, 0, 32'hCAFEF00D, 2, 1, t);

        // SB merges lane 1 one cycle after accept
        issue("sb_11", 0, 1, S_BYTE, 32'h11, 32'h000000CC, 0, 32'd0, 2, 1, t);
        @(negedge clk);
        #1;
        chk("sb_11_mem_we_T1", 32'(bus.mem_we),    32'd1);
        chk("sb_11_waddr_T1",  32'(bus.mem_waddr), 32'd4);
        chk("sb_11_wdata_T1",  bus.mem_wdata,      32'h8899CCBB);
        issue("lw_10_after_sb", 1, 0, L_WORD, 32'h10, 0, 0, 32'h8899CCBB, 2, 1, t);

        // SH into the upper half of word 0x14 = 0x11223344
        issue("sh_16", 0, 1, S_HALF, 32'h16, 32'h0000BEEF, 0, 32'd0, 2, 1, t);
        @(negedge clk);
        #1;
        chk("sh_16_mem_we_T1", 32'(bus.mem_we), 32'd1);
        chk("sh_16_wdata_T1",  bus.mem_wdata,   32'hBEEF3344);
        issue("lh_16",  1, 0, L_HALF,   32'h16, 0, 0, 32'hFFFFBEEF, 2, 1, t);
        issue("lbu_15", 1, 0, L_BYTE_U, 32'h15, 0, 0, 32'h00000033, 2, 1, t);

        // SW then back-to-back LW of the same word
        issue("sw_20", 0, 1, S_WORD, 32'h20, 32'h12345678, 0, 32'd0, 1, 1, t_sw);
        issue("lw_20", 1, 0, L_WORD, 32'h20, 0, 0, 32'h12345678, 2, 1, t_lw);
        chk("b2b_accept_gap", 32'(t_lw - t_sw), 32'd2);
        drain("pre_err");

        // Error cases: response after 1 cycle, no RAM strobes at all
        @(negedge clk);
        acc_before = n_re + n_we;
        issue("err_lw_22",   1, 0, L_WORD, 32'h22,   0, 1, 32'd0, 1, 1, t);
        issue("err_sh_21",   0, 1, S_HALF, 32'h21,   32'h55, 1, 32'd0, 1, 1, t);
        issue("err_lw_1000", 1, 0, L_WORD, 32'h1000, 0, 1, 32'd0, 1, 1, t);
        issue("err_re_we",   1, 1, L_WORD, 32'h10,   0, 1, 32'd0, 1, 1, t);
        issue("err_ld_f3",   1, 0, 3'b011, 32'h10,   0, 1, 32'd0, 1, 1, t);
        issue("err_st_f3",   0, 1, 3'b100, 32'h10,   0, 1, 32'd0, 1, 1, t);
        drain("err");
        @(negedge clk);
        chk("err_no_mem_access", 32'(n_re + n_we - acc_before), 32'd0);

        // Reset during the merge cycle of an SB must drop the write and the response
        issue("sb_rst", 0, 1, S_BYTE, 32'h11, 32'h000000EE, 0, 32'd0, 2, 0, t);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_resp_data",  bus.resp_data,       32'd0);
        chk("rst_mid_resp_err",   32'(bus.resp_err),   32'd0);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready",      32'(bus.req_ready),  32'd1);
        repeat (3) @(negedge clk);
        issue("lw_10_after_rst", 1, 0, L_WORD, 32'h10, 0, 0, 32'h8899CCBB, 2, 1, t);
        drain("final");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #100000;
        $display("FAIL global_timeout: got cyc=%0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
